// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and timing limits for the SPI transmitter
package spi_pkg;
   typedef enum logic [2:0] {IDLE, SETUP, CLK_HIGH, CLK_LOW, HOLD, GAP} spi_tx_state_t;
   localparam int SPI_MIN_HALF = 4;
endpackage

// File: rtl/spi_tx.sv
// spi_tx: MSB-first SPI controller transmitter, idle-low DCLK, active-low select
module spi_tx
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DCLK_HALF  = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  trigger_in,
   output logic                  ready_out,
   output logic                  done_out,
   output logic                  chip_data_out,
   output logic                  chip_clk_out,
   output logic                  chip_sel_out
);
   localparam int CMAX = DCLK_HALF > GAP_CYCLES ? DCLK_HALF : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int BW   = $clog2(DATA_WIDTH);

   if (DCLK_HALF < SPI_MIN_HALF || GAP_CYCLES < 1 || DATA_WIDTH < 2) begin : g_bad_params
      $error("spi_tx: illegal parameters");
   end

   spi_tx_state_t         state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic                  ready_q, ready_d, done_q, done_d;
   logic                  dat_q, dat_d, sclk_q, sclk_d, sel_q, sel_d;
   logic                  accept, tc_half, tc_gap, last;

   assign accept  = state_q == IDLE && trigger_in;
   assign tc_half = cnt_q == CW'(DCLK_HALF - 1);
   assign tc_gap  = cnt_q == CW'(GAP_CYCLES - 1);
   assign last    = bit_q == BW'(DATA_WIDTH - 1);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         dat_q   <= 1'b0;
         sclk_q  <= 1'b0;
         sel_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         dat_q   <= dat_d;
         sclk_q  <= sclk_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = accept ? SETUP : IDLE;
         SETUP:    state_d = tc_half ? CLK_HIGH : SETUP;
         CLK_HIGH: state_d = tc_half ? (last ? HOLD : CLK_LOW) : CLK_HIGH;
         CLK_LOW:  state_d = tc_half ? CLK_HIGH : CLK_LOW;
         HOLD:     state_d = tc_half ? GAP : HOLD;
         GAP:      state_d = tc_gap ? IDLE : GAP;
         default:  state_d = IDLE;
      endcase
      // counter restarts on every state change so it never wraps inside a state
      cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
   end

   always_comb begin
      sh_d    = sh_q;
      bit_d   = bit_q;
      dat_d   = dat_q;
      sclk_d  = sclk_q;
      sel_d   = sel_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            sh_d    = data_in;
            bit_d   = '0;
            sel_d   = 1'b0;
            dat_d   = data_in[DATA_WIDTH-1];
            ready_d = 1'b0;
         end
         SETUP, CLK_LOW: if (tc_half) sclk_d = 1'b1;
         CLK_HIGH: if (tc_half) begin
            sclk_d = 1'b0;
            if (!last) begin
               dat_d = sh_q[DATA_WIDTH-2];
               sh_d  = {sh_q[DATA_WIDTH-2:0], 1'b0};
               bit_d = bit_q + BW'(1);
            end
         end
         HOLD: if (tc_half) begin
            sel_d  = 1'b1;
            dat_d  = 1'b0;
            done_d = 1'b1;
         end
         GAP: if (tc_gap) ready_d = 1'b1;
         default: ;
      endcase
   end

   assign ready_out     = ready_q;
   assign done_out      = done_q;
   assign chip_data_out = dat_q;
   assign chip_clk_out  = sclk_q;
   assign chip_sel_out  = sel_q;
endmodule
